// File: rtl/axis_py_lockin_pw_if.sv
// Stream bundle for the lock-in block: signal, sine/cosine and DDS period inputs,
// plus the X/Y/A2 mean outputs and the window-full flag.
interface axis_py_lockin_pw_if #(
  parameter int SIG_WIDTH = 32,
  parameter int OUT_WIDTH = 32
);
  logic [SIG_WIDTH-1:0]   S_AXIS_SIGNAL_tdata;
  logic                   S_AXIS_SIGNAL_tvalid;
  logic [63:0]            S_AXIS_SC_tdata;
  logic                   S_AXIS_SC_tvalid;
  logic [15:0]            S_AXIS_DDS_N2_tdata;
  logic                   S_AXIS_DDS_N2_tvalid;
  logic [OUT_WIDTH-1:0]   M_AXIS_X_tdata;
  logic                   M_AXIS_X_tvalid;
  logic [OUT_WIDTH-1:0]   M_AXIS_Y_tdata;
  logic                   M_AXIS_Y_tvalid;
  logic [2*OUT_WIDTH-1:0] M_AXIS_A2_tdata;
  logic                   M_AXIS_A2_tvalid;
  logic                   window_full;

  modport master (
    output S_AXIS_SIGNAL_tdata, S_AXIS_SIGNAL_tvalid,
    output S_AXIS_SC_tdata, S_AXIS_SC_tvalid,
    output S_AXIS_DDS_N2_tdata, S_AXIS_DDS_N2_tvalid,
    input  M_AXIS_X_tdata, M_AXIS_X_tvalid,
    input  M_AXIS_Y_tdata, M_AXIS_Y_tvalid,
    input  M_AXIS_A2_tdata, M_AXIS_A2_tvalid,
    input  window_full
  );

  modport slave (
    input  S_AXIS_SIGNAL_tdata, S_AXIS_SIGNAL_tvalid,
    input  S_AXIS_SC_tdata, S_AXIS_SC_tvalid,
    input  S_AXIS_DDS_N2_tdata, S_AXIS_DDS_N2_tvalid,
    output M_AXIS_X_tdata, M_AXIS_X_tvalid,
    output M_AXIS_Y_tdata, M_AXIS_Y_tvalid,
    output M_AXIS_A2_tdata, M_AXIS_A2_tvalid,
    output window_full
  );
endinterface

// File: rtl/axis_py_lockin_pw.sv
// Lock-in demodulator: decimate, multiply by sine/cosine, then take a sliding
// period-window mean of each product plus the squared magnitude. Six-cycle pipeline.
module axis_py_lockin_pw #(
  parameter int SIG_WIDTH  = 32,
  parameter int Q_WIDTH    = 24,
  parameter int SC_WIDTH   = 25,
  parameter int OUT_WIDTH  = 32,
  parameter int BUF_LEN2   = 10,
  parameter int DECII2_MAX = 16,
  parameter int N2_DEFAULT = 10
) (
  input logic               a_clk,
  input logic               a_rst,
  axis_py_lockin_pw_if.slave bus
);

  localparam int PW    = Q_WIDTH + SC_WIDTH;
  localparam int SH    = PW - OUT_WIDTH;
  localparam int AW    = Q_WIDTH + DECII2_MAX;
  localparam int SW    = OUT_WIDTH + BUF_LEN2;
  localparam int FW    = BUF_LEN2 + 1;
  localparam int GW    = DECII2_MAX + 1;
  localparam int A2W   = 2 * OUT_WIDTH;
  localparam int WIN_W = $clog2(BUF_LEN2 + 1);
  localparam int DEC_W = $clog2(DECII2_MAX + 1);
  localparam int DEPTH = 1 << BUF_LEN2;

  function automatic logic [DEC_W-1:0] cfg_decii(input logic [15:0] n2);
    logic [15:0] d;
    d = 16'd0;
    if (n2 > 16'(BUF_LEN2)) begin
      d = n2 - 16'(BUF_LEN2);
      if (d > 16'(DECII2_MAX)) d = 16'(DECII2_MAX);
    end
    return DEC_W'(d);
  endfunction

  function automatic logic [WIN_W-1:0] cfg_win(input logic [15:0] n2);
    return (n2 > 16'(BUF_LEN2)) ? WIN_W'(BUF_LEN2) : WIN_W'(n2);
  endfunction

  function automatic logic signed [Q_WIDTH-1:0] decimate(input logic signed [AW-1:0] a,
                                                         input logic [DEC_W-1:0] sh);
    return Q_WIDTH'(a >>> sh);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] norm(input logic signed [PW-1:0] p);
    return OUT_WIDTH'(p >>> SH);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] mean(input logic signed [SW-1:0] s,
                                                       input logic [WIN_W-1:0] sh);
    return OUT_WIDTH'(s >>> sh);
  endfunction

  function automatic logic [A2W-1:0] mag2(input logic signed [OUT_WIDTH-1:0] x,
                                          input logic signed [OUT_WIDTH-1:0] y);
    logic signed [A2W-1:0] xx;
    logic signed [A2W-1:0] yy;
    xx = A2W'(x) * A2W'(x);
    yy = A2W'(y) * A2W'(y);
    return $unsigned(xx + yy);
  endfunction

  logic [15:0]                 r_n2;
  logic [WIN_W-1:0]            r_win2;
  logic [DEC_W-1:0]            r_decii2;
  logic [GW-1:0]               r_grp;
  logic signed [AW-1:0]        r_acc;
  logic                        r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
  logic signed [Q_WIDTH-1:0]   r_dec_p0;
  logic signed [SC_WIDTH-1:0]  r_s_p0, r_c_p0;
  logic signed [PW-1:0]        r_px_p1, r_py_p1;
  logic signed [OUT_WIDTH-1:0] r_px_p2, r_py_p2;
  logic signed [OUT_WIDTH-1:0] r_mem_x [DEPTH];
  logic signed [OUT_WIDTH-1:0] r_mem_y [DEPTH];
  logic [BUF_LEN2-1:0]         r_wr;
  logic [FW-1:0]               r_fill;
  logic                        r_full;
  logic signed [SW-1:0]        r_sum_x, r_sum_y;
  logic signed [OUT_WIDTH-1:0] r_x_p4, r_y_p4;
  logic [OUT_WIDTH-1:0]        r_x_out, r_y_out;
  logic [A2W-1:0]              r_a2_out;
  logic                        r_tvalid;

  logic signed [Q_WIDTH-1:0]   w_sig;
  logic signed [SC_WIDTH-1:0]  w_s, w_c;
  logic                        w_upd, w_take, w_grp_done;
  logic [GW-1:0]               w_grp_last;
  logic signed [AW-1:0]        w_acc_sum;
  logic [FW-1:0]               w_len, w_fill_nx;
  logic [BUF_LEN2-1:0]         w_mask;
  logic                        w_full_nx;
  logic signed [OUT_WIDTH-1:0] w_old_x, w_old_y;
  logic                        w_unused_bits;

  assign w_sig = $signed(bus.S_AXIS_SIGNAL_tdata[SIG_WIDTH-1 -: Q_WIDTH]);
  assign w_c   = $signed(bus.S_AXIS_SC_tdata[0 +: SC_WIDTH]);
  assign w_s   = $signed(bus.S_AXIS_SC_tdata[32 +: SC_WIDTH]);
  assign w_unused_bits = ^{bus.S_AXIS_SIGNAL_tdata, bus.S_AXIS_SC_tdata};

  // A period change outranks a sample arriving in the same cycle.
  assign w_upd      = bus.S_AXIS_DDS_N2_tvalid && (bus.S_AXIS_DDS_N2_tdata != r_n2);
  assign w_take     = bus.S_AXIS_SIGNAL_tvalid && bus.S_AXIS_SC_tvalid && !w_upd;
  assign w_grp_last = (GW'(1) << r_decii2) - GW'(1);
  assign w_grp_done = w_take && (r_grp == w_grp_last);
  assign w_acc_sum  = r_acc + AW'(w_sig);

  assign w_len     = FW'(1) << r_win2;
  assign w_mask    = BUF_LEN2'(w_len - FW'(1));
  assign w_fill_nx = r_full ? r_fill : r_fill + FW'(1);
  assign w_full_nx = (w_fill_nx == w_len);
  assign w_old_x   = r_full ? r_mem_x[r_wr] : '0;
  assign w_old_y   = r_full ? r_mem_y[r_wr] : '0;

  // Stage p0: configuration, decimation accumulate, group capture
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_n2     <= 16'(N2_DEFAULT);
      r_win2   <= cfg_win(16'(N2_DEFAULT));
      r_decii2 <= cfg_decii(16'(N2_DEFAULT));
      r_grp    <= '0;
      r_acc    <= '0;
      r_vld_p0 <= 1'b0;
    end else if (w_upd) begin
      r_n2     <= bus.S_AXIS_DDS_N2_tdata;
      r_win2   <= cfg_win(bus.S_AXIS_DDS_N2_tdata);
      r_decii2 <= cfg_decii(bus.S_AXIS_DDS_N2_tdata);
      r_grp    <= '0;
      r_acc    <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_grp_done;
      if (w_grp_done) begin
        r_grp <= '0;
        r_acc <= '0;
      end else if (w_take) begin
        r_grp <= r_grp + GW'(1);
        r_acc <= w_acc_sum;
      end
    end
  end

  always_ff @(posedge a_clk) begin
    if (w_grp_done) begin
      r_dec_p0 <= decimate(w_acc_sum, r_decii2);
      r_s_p0   <= w_s;
      r_c_p0   <= w_c;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst || w_upd) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p4 <= 1'b0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      r_vld_p4 <= r_vld_p3;
    end
  end

  // Stage p1: full-precision products
  always_ff @(posedge a_clk) begin
    r_px_p1 <= PW'(r_s_p0) * PW'(r_dec_p0);
    r_py_p1 <= PW'(r_c_p0) * PW'(r_dec_p0);
  end

  // Stage p2: normalise to output width
  always_ff @(posedge a_clk) begin
    r_px_p2 <= norm(r_px_p1);
    r_py_p2 <= norm(r_py_p1);
  end

  // Stage p3: sliding-window sums; the fill count gates out stale memory
  always_ff @(posedge a_clk) begin
    if (r_vld_p2 && !w_upd) begin
      r_mem_x[r_wr] <= r_px_p2;
      r_mem_y[r_wr] <= r_py_p2;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst || w_upd) begin
      r_wr     <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
      r_sum_x  <= '0;
      r_sum_y  <= '0;
      r_vld_p3 <= 1'b0;
    end else begin
      r_vld_p3 <= r_vld_p2 && w_full_nx;
      if (r_vld_p2) begin
        r_sum_x <= r_sum_x + SW'(r_px_p2) - SW'(w_old_x);
        r_sum_y <= r_sum_y + SW'(r_py_p2) - SW'(w_old_y);
        r_wr    <= (r_wr + BUF_LEN2'(1)) & w_mask;
        r_fill  <= w_fill_nx;
        r_full  <= w_full_nx;
      end
    end
  end

  // Stage p4: window means
  always_ff @(posedge a_clk) begin
    r_x_p4 <= mean(r_sum_x, r_win2);
    r_y_p4 <= mean(r_sum_y, r_win2);
  end

  // Stage p5: output registers; data holds between pulses and across a flush
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_x_out  <= '0;
      r_y_out  <= '0;
      r_a2_out <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_tvalid <= r_vld_p4 && !w_upd;
      if (r_vld_p4 && !w_upd) begin
        r_x_out  <= r_x_p4;
        r_y_out  <= r_y_p4;
        r_a2_out <= mag2(r_x_p4, r_y_p4);
      end
    end
  end

  assign bus.M_AXIS_X_tdata   = r_x_out;
  assign bus.M_AXIS_Y_tdata   = r_y_out;
  assign bus.M_AXIS_A2_tdata  = r_a2_out;
  assign bus.M_AXIS_X_tvalid  = r_tvalid;
  assign bus.M_AXIS_Y_tvalid  = r_tvalid;
  assign bus.M_AXIS_A2_tvalid = r_tvalid;
  assign bus.window_full      = r_full;

endmodule
